// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with oversampled deframing feeding a small show-ahead FIFO.
// Good bytes are queued; dropped-byte and bad-stop-bit events raise sticky flags.
module uart_rx_fifo #(
   parameter int clk_freq_hz = 10_000_000,
   parameter int baud_rate   = 1_000_000,
   parameter int fifo_aw     = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   input  logic       i_rd,
   input  logic       i_clr_err,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_overrun,
   output logic       o_frame_err
);
   localparam int CPB   = clk_freq_hz / baud_rate;
   localparam int CW    = $clog2(CPB) + 1;
   localparam int DEPTH = 2 ** fifo_aw;

   localparam logic [CW-1:0]      CNT_HALF = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0]      CNT_FULL = CW'(CPB - 1);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [fifo_aw-1:0] PTR_ONE  = fifo_aw'(1);
   localparam logic [fifo_aw:0]   FCNT_ONE = (fifo_aw + 1)'(1);
   localparam logic [fifo_aw:0]   FCNT_MAX = (fifo_aw + 1)'(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   generate
      if (CPB < 4) begin : g_cpb_check
         $error("uart_rx_fifo: clk_freq_hz/baud_rate must be at least 4");
      end
   endgenerate

   logic                sync1_q, sync2_q, rx_prev_q;
   logic                rx_s;
   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                push_req, ferr_set;

   logic [7:0]          mem_q [DEPTH];
   logic [fifo_aw-1:0]  wr_ptr_q, rd_ptr_q;
   logic [fifo_aw:0]    count_q, count_d;
   logic                full, empty, do_pop, do_push, ovr_set;
   logic                overrun_q, frame_err_q;

   assign rx_s = sync2_q;

   // Deframer: every line decision is taken on the synchronized rx_s.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push_req = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s && rx_prev_q) begin
               cnt_d   = CNT_HALF;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = CNT_FULL;
                  bit_d   = 3'd0;
                  state_d = S_DATA;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = CNT_FULL;
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            if (cnt_q == '0) begin
               state_d  = S_IDLE;
               push_req = rx_s;
               ferr_set = ~rx_s;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
      end else begin
         sync1_q   <= i_rx;
         sync2_q   <= sync1_q;
         rx_prev_q <= rx_s;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
      end
   end

   // A pop frees the slot a simultaneous push needs, so a full FIFO read in
   // the push cycle does not overrun.
   assign full    = (count_q == FCNT_MAX);
   assign empty   = (count_q == '0);
   assign do_pop  = i_rd & ~empty;
   assign do_push = push_req & (~full | do_pop);
   assign ovr_set = push_req & full & ~do_pop;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)      count_d = count_q + FCNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - FCNT_ONE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q     <= count_d;
         overrun_q   <= ovr_set  | (overrun_q   & ~i_clr_err);
         frame_err_q <= ferr_set | (frame_err_q & ~i_clr_err);
      end
   end

   assign o_data      = mem_q[rd_ptr_q];
   assign o_valid     = ~empty;
   assign o_overrun   = overrun_q;
   assign o_frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based model predicts the FIFO
// and flags per cycle from when each serial frame was launched.
module tb_uart_rx_fifo;
   localparam int CPB   = 10;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_rx = 1'b1;
   logic       i_rd = 1'b0;
   logic       i_clr_err = 1'b0;
   logic [7:0] o_data;
   logic       o_valid, o_overrun, o_frame_err;

   uart_rx_fifo #(
      .clk_freq_hz(10_000_000),
      .baud_rate  (1_000_000),
      .fifo_aw    (2)
   ) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_rx       (i_rx),
      .i_rd       (i_rd),
      .i_clr_err  (i_clr_err),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_overrun  (o_overrun),
      .o_frame_err(o_frame_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic [7:0] mq[$];
   bit         m_ovr = 1'b0;
   bit         m_fe = 1'b0;
   int         ev_kind[int];
   logic [7:0] ev_byte[int];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // A frame launched in cycle c (start bit driven after edge c) resolves at
   // edge c+98: two sync stages plus CPB/2 + 9*CPB to the stop sample plus one.
   always @(posedge clk) begin : model
      bit pop, set_o, set_f;
      cyc = cyc + 1;
      if (i_rst) begin
         mq.delete();
         m_ovr = 1'b0;
         m_fe  = 1'b0;
         ev_kind.delete();
         ev_byte.delete();
         chk_en = 1'b1;
      end else begin
         set_o = 1'b0;
         set_f = 1'b0;
         pop = i_rd && (mq.size() > 0);
         if (pop) void'(mq.pop_front());
         if (ev_kind.exists(cyc)) begin
            if (ev_kind[cyc] == 1) begin
               if (mq.size() < DEPTH) mq.push_back(ev_byte[cyc]);
               else set_o = 1'b1;
            end else begin
               set_f = 1'b1;
            end
            ev_kind.delete(cyc);
            ev_byte.delete(cyc);
         end
         m_ovr = set_o | (m_ovr & ~i_clr_err);
         m_fe  = set_f | (m_fe & ~i_clr_err);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", {31'd0, o_valid}, {31'd0, mq.size() > 0});
         if (mq.size() > 0) chk("data", {24'd0, o_data}, {24'd0, mq[0]});
         chk("overrun", {31'd0, o_overrun}, {31'd0, m_ovr});
         chk("frame_err", {31'd0, o_frame_err}, {31'd0, m_fe});
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop, input int abort_bit);
      logic [7:0] v;
      v = b;
      i_rx = 1'b0;
      ev_kind[cyc + 98] = stop ? 1 : 2;
      ev_byte[cyc + 98] = v;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         i_rx = v[i];
         if (i == abort_bit) begin
            tick(CPB / 2);
            return;
         end
         tick(CPB);
      end
      i_rx = stop;
      tick(CPB);
      i_rx = 1'b1;
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] exp);
      @(negedge clk);
      chk({nm, "_valid"}, {31'd0, o_valid}, 32'd1);
      chk(nm, {24'd0, o_data}, {24'd0, exp});
      @(posedge clk);
      #1 i_rd = 1'b1;
      tick(1);
      i_rd = 1'b0;
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      @(negedge clk);
      chk(nm, act, exp);
   endtask

   task automatic clr_pulse();
      i_clr_err = 1'b1;
      tick(1);
      i_clr_err = 1'b0;
   endtask

   bit rnd_done;

   initial begin
      tick(3);
      i_rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_data", {24'd0, o_data}, 32'h00);
      chk("rst_ovr", {31'd0, o_overrun}, 32'd0);
      chk("rst_ferr", {31'd0, o_frame_err}, 32'd0);
      tick(5);

      // 1: first-byte latency
      fork
         send_frame(8'hA5, 1'b1, -1);
         begin
            tick(97);
            @(negedge clk);
            chk("t1_valid_at_97", {31'd0, o_valid}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("t1_valid_at_98", {31'd0, o_valid}, 32'd1);
            chk("t1_data", {24'd0, o_data}, 32'hA5);
         end
      join
      tick(2);
      pop_chk("t1_pop", 8'hA5);
      lit("t1_empty", {31'd0, o_valid}, 32'd0);

      // 2: fill to full
      send_frame(8'h01, 1'b1, -1);
      send_frame(8'h80, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      send_frame(8'h00, 1'b1, -1);
      tick(5);
      pop_chk("t2_b0", 8'h01);
      pop_chk("t2_b1", 8'h80);
      pop_chk("t2_b2", 8'hFF);
      pop_chk("t2_b3", 8'h00);
      lit("t2_flags", {30'd0, o_overrun, o_frame_err}, 32'd0);

      // 3: overrun, then read coinciding with the fifth push
      for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, -1);
      tick(5);
      lit("t3_ovr_set", {31'd0, o_overrun}, 32'd1);
      for (int i = 0; i < 4; i++) pop_chk("t3_keep", 8'h10 + 8'(i));
      lit("t3_empty", {31'd0, o_valid}, 32'd0);
      clr_pulse();
      lit("t3_ovr_clr", {31'd0, o_overrun}, 32'd0);
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, -1);
      fork
         send_frame(8'h14, 1'b1, -1);
         begin
            tick(97);
            i_rd = 1'b1;
            tick(1);
            i_rd = 1'b0;
         end
      join
      tick(3);
      lit("t3_no_ovr", {31'd0, o_overrun}, 32'd0);
      for (int i = 1; i < 5; i++) pop_chk("t3_rdpush", 8'h10 + 8'(i));

      // 4: bad stop bit
      send_frame(8'h3C, 1'b0, -1);
      tick(3);
      lit("t4_ferr", {31'd0, o_frame_err}, 32'd1);
      lit("t4_novalid", {31'd0, o_valid}, 32'd0);
      clr_pulse();
      lit("t4_ferr_clr", {31'd0, o_frame_err}, 32'd0);
      send_frame(8'h55, 1'b1, -1);
      tick(3);
      pop_chk("t4_good", 8'h55);

      // 5: glitch, then line held low
      i_rx = 1'b0;
      tick(3);
      i_rx = 1'b1;
      tick(150);
      lit("t5_glitch", {29'd0, o_valid, o_overrun, o_frame_err}, 32'd0);
      ev_kind[cyc + 98] = 2;
      ev_byte[cyc + 98] = 8'h00;
      i_rx = 1'b0;
      tick(200);
      i_rx = 1'b1;
      tick(150);
      lit("t5_held_low", {29'd0, o_valid, o_overrun, o_frame_err}, 32'd1);

      // 6: reset mid-frame with a byte queued and a flag set
      send_frame(8'h77, 1'b1, -1);
      tick(3);
      send_frame(8'hC3, 1'b1, 4);
      i_rx = 1'b1;
      i_rst = 1'b1;
      tick(3);
      i_rst = 1'b0;
      lit("t6_rst_state", {21'd0, o_data, o_valid, o_overrun, o_frame_err}, 32'd0);
      tick(150);
      lit("t6_no_partial", {31'd0, o_valid}, 32'd0);
      send_frame(8'hC3, 1'b1, -1);
      tick(3);
      pop_chk("t6_c3", 8'hC3);

      // Random frames, reads and flag clears against the model
      rnd_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               logic [7:0] rb;
               bit rs;
               rb = 8'($urandom);
               rs = ($urandom_range(0, 7) != 0);
               send_frame(rb, rs, -1);
               tick(rs ? $urandom_range(0, 3) : $urandom_range(1, 5));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               i_rd = ($urandom_range(0, 199) < 2);
               i_clr_err = ($urandom_range(0, 199) < 1);
               tick(1);
            end
            i_rd = 1'b0;
            i_clr_err = 1'b0;
         end
      join
      tick(120);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
